// File: rtl/player_mover_pkg.sv
// Shared constants, direction bit indices and FSM encoding for the maze player mover.
package player_mover_pkg;

    localparam int CELL_SIZE   = 16;
    localparam int MAZE_X0     = 64;
    localparam int MAZE_Y0     = 64;
    localparam int MAZE_W      = 30;
    localparam int MAZE_H      = 12;
    localparam int PLAYER_SIZE = 8;
    localparam int STEP        = 2;
    localparam int START_X     = 80;
    localparam int START_Y     = 80;

    // Held-key vector layout {up,down,left,right}
    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    // Allowed range of the candidate top-left corner so the whole box stays inside the maze
    localparam logic signed [10:0] REGION_X_MIN = 11'(MAZE_X0);
    localparam logic signed [10:0] REGION_X_MAX = 11'(MAZE_X0 + MAZE_W * CELL_SIZE - PLAYER_SIZE);
    localparam logic signed [10:0] REGION_Y_MIN = 11'(MAZE_Y0);
    localparam logic signed [10:0] REGION_Y_MAX = 11'(MAZE_Y0 + MAZE_H * CELL_SIZE - PLAYER_SIZE);
    localparam logic signed [10:0] STEP_S       = 11'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROBE_A = 2'd1,
        ST_PROBE_B = 2'd2,
        ST_DECIDE  = 2'd3
    } state_e;

endpackage

// File: rtl/player_corner_calc.sv
// Leading-corner probe coordinates and maze-region test for a candidate player box.
module player_corner_calc
    import player_mover_pkg::*;
(
    input  logic [3:0]         dir_i,
    input  logic signed [10:0] cand_x_i,
    input  logic signed [10:0] cand_y_i,
    output logic [9:0]         corner_a_x_o,
    output logic [8:0]         corner_a_y_o,
    output logic [9:0]         corner_b_x_o,
    output logic [8:0]         corner_b_y_o,
    output logic               in_region_o
);

    logic [9:0] left_x;
    logic [9:0] right_x;
    logic [8:0] top_y;
    logic [8:0] bottom_y;

    // Low bits are enough for the probe: an out-of-region candidate is never probed
    assign left_x   = cand_x_i[9:0];
    assign right_x  = cand_x_i[9:0] + 10'(PLAYER_SIZE - 1);
    assign top_y    = cand_y_i[8:0];
    assign bottom_y = cand_y_i[8:0] + 9'(PLAYER_SIZE - 1);

    assign in_region_o = (cand_x_i >= REGION_X_MIN) && (cand_x_i <= REGION_X_MAX) &&
                         (cand_y_i >= REGION_Y_MIN) && (cand_y_i <= REGION_Y_MAX);

    always_comb begin
        corner_a_x_o = left_x;
        corner_a_y_o = top_y;
        corner_b_x_o = left_x;
        corner_b_y_o = bottom_y;
        if (dir_i[DIR_UP]) begin
            corner_b_x_o = right_x;
            corner_b_y_o = top_y;
        end else if (dir_i[DIR_DOWN]) begin
            corner_a_y_o = bottom_y;
            corner_b_x_o = right_x;
        end else if (dir_i[DIR_RIGHT]) begin
            corner_a_x_o = right_x;
            corner_b_x_o = right_x;
        end
    end

endmodule

// File: rtl/player_mover.sv
// Frame-tick player mover: probes two leading corners against the wall map, then moves or bumps.
// Optional bump counter output enabled by defining PLAYER_BUMP_CNT_EN.
module player_mover
    import player_mover_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic [3:0] dir,
    input  logic       map_is_wall,
    output logic [9:0] query_x,
    output logic [8:0] query_y,
    output logic [9:0] player_x,
    output logic [8:0] player_y,
    output logic       busy,
    output logic       moved,
    output logic       bump
`ifdef PLAYER_BUMP_CNT_EN
    ,
    output logic [7:0] bump_count
`endif
);

    state_e             state_q, state_d;
    logic [3:0]         dir_q, dir_d;
    logic signed [10:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic               blocked_q, blocked_d;
    logic               wall_a_q, wall_a_d, wall_b_q, wall_b_d;
    logic [9:0]         query_x_q, query_x_d, player_x_q, player_x_d;
    logic [8:0]         query_y_q, query_y_d, player_y_q, player_y_d;
    logic               moved_q, moved_d, bump_q, bump_d;

    logic signed [10:0] pos_x_s, pos_y_s;
    logic [9:0]         corner_a_x, corner_b_x;
    logic [8:0]         corner_a_y, corner_b_y;
    logic               in_region;
    logic               start_move;

    assign pos_x_s    = signed'({1'b0, player_x_q});
    assign pos_y_s    = signed'({2'b0, player_y_q});
    assign start_move = (state_q == ST_IDLE) && frame_tick && (dir != 4'd0);

    // While idle the corner calculator sees the fresh candidate; afterwards the latched one
    always_comb begin
        dir_d    = dir_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        if (state_q == ST_IDLE) begin
            dir_d    = 4'd0;
            cand_x_d = pos_x_s;
            cand_y_d = pos_y_s;
            if (dir[DIR_UP]) begin
                dir_d[DIR_UP] = 1'b1;
                cand_y_d      = pos_y_s - STEP_S;
            end else if (dir[DIR_DOWN]) begin
                dir_d[DIR_DOWN] = 1'b1;
                cand_y_d        = pos_y_s + STEP_S;
            end else if (dir[DIR_LEFT]) begin
                dir_d[DIR_LEFT] = 1'b1;
                cand_x_d        = pos_x_s - STEP_S;
            end else if (dir[DIR_RIGHT]) begin
                dir_d[DIR_RIGHT] = 1'b1;
                cand_x_d         = pos_x_s + STEP_S;
            end
        end
    end

    player_corner_calc u_corner_calc (
        .dir_i        (dir_d),
        .cand_x_i     (cand_x_d),
        .cand_y_i     (cand_y_d),
        .corner_a_x_o (corner_a_x),
        .corner_a_y_o (corner_a_y),
        .corner_b_x_o (corner_b_x),
        .corner_b_y_o (corner_b_y),
        .in_region_o  (in_region)
    );

    always_comb begin
        state_d    = state_q;
        blocked_d  = blocked_q;
        wall_a_d   = wall_a_q;
        wall_b_d   = wall_b_q;
        query_x_d  = query_x_q;
        query_y_d  = query_y_q;
        player_x_d = player_x_q;
        player_y_d = player_y_q;
        moved_d    = 1'b0;
        bump_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_move) begin
                    if (in_region) begin
                        blocked_d = 1'b0;
                        query_x_d = corner_a_x;
                        query_y_d = corner_a_y;
                        state_d   = ST_PROBE_A;
                    end else begin
                        blocked_d = 1'b1;
                        state_d   = ST_DECIDE;
                    end
                end
            end
            ST_PROBE_A: begin
                wall_a_d  = map_is_wall;
                query_x_d = corner_b_x;
                query_y_d = corner_b_y;
                state_d   = ST_PROBE_B;
            end
            ST_PROBE_B: begin
                wall_b_d = map_is_wall;
                state_d  = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (!(wall_a_q || wall_b_q || blocked_q)) begin
                    player_x_d = cand_x_q[9:0];
                    player_y_d = cand_y_q[8:0];
                    moved_d    = 1'b1;
                end else begin
                    bump_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            dir_q      <= 4'd0;
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            blocked_q  <= 1'b0;
            wall_a_q   <= 1'b0;
            wall_b_q   <= 1'b0;
            query_x_q  <= '0;
            query_y_q  <= '0;
            player_x_q <= 10'(START_X);
            player_y_q <= 9'(START_Y);
            moved_q    <= 1'b0;
            bump_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            blocked_q  <= blocked_d;
            wall_a_q   <= wall_a_d;
            wall_b_q   <= wall_b_d;
            query_x_q  <= query_x_d;
            query_y_q  <= query_y_d;
            player_x_q <= player_x_d;
            player_y_q <= player_y_d;
            moved_q    <= moved_d;
            bump_q     <= bump_d;
        end
    end

`ifdef PLAYER_BUMP_CNT_EN
    logic [7:0] bump_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bump_cnt_q <= 8'd0;
        end else if (bump_d && (bump_cnt_q != 8'hFF)) begin
            bump_cnt_q <= bump_cnt_q + 8'd1;
        end
    end

    assign bump_count = bump_cnt_q;
`endif

    assign query_x  = query_x_q;
    assign query_y  = query_y_q;
    assign player_x = player_x_q;
    assign player_y = player_y_q;
    assign busy     = (state_q != ST_IDLE);
    assign moved    = moved_q;
    assign bump     = bump_q;

endmodule

// File: tb/tb_player_mover.sv
// Directed self-checking bench for player_mover against a behavioural 30x12 maze map.
module tb_player_mover;

    logic       clk;
    logic       resetn;
    logic       frame_tick;
    logic [3:0] dir;
    logic       map_is_wall;
    logic [9:0] query_x;
    logic [8:0] query_y;
    logic [9:0] player_x;
    logic [8:0] player_y;
    logic       busy;
    logic       moved;
    logic       bump;
`ifdef PLAYER_BUMP_CNT_EN
    logic [7:0] bump_count;
`endif

    logic stub_open;
    int   checks;
    int   failures;

    player_mover dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_tick  (frame_tick),
        .dir         (dir),
        .map_is_wall (map_is_wall),
        .query_x     (query_x),
        .query_y     (query_y),
        .player_x    (player_x),
        .player_y    (player_y),
        .busy        (busy),
        .moved       (moved),
        .bump        (bump)
`ifdef PLAYER_BUMP_CNT_EN
        ,
        .bump_count  (bump_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Border ring of walls plus one interior wall segment in column 10, rows 3..11
    function automatic logic maze_wall(input logic [9:0] x, input logic [8:0] y);
        int col;
        int row;
        if (x < 10'd64 || x >= 10'd544 || y < 9'd64 || y >= 9'd256) return 1'b1;
        col = (int'(x) - 64) / 16;
        row = (int'(y) - 64) / 16;
        if (col == 0 || col == 29 || row == 0 || row == 11) return 1'b1;
        if (col == 10 && row >= 3) return 1'b1;
        return 1'b0;
    endfunction

    always_comb map_is_wall = stub_open ? 1'b0 : maze_wall(query_x, query_y);

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // result: 1 = moved, 2 = bump, 0 = nothing within the cycle budget
    task automatic do_move(input logic [3:0] d, output int result);
        frame_tick = 1'b1;
        dir        = d;
        step_cycle();
        frame_tick = 1'b0;
        result     = 0;
        for (int i = 0; i < 6 && result == 0; i++) begin
            step_cycle();
            if (moved) result = 1;
            else if (bump) result = 2;
        end
        dir = 4'd0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        step_cycle();
        step_cycle();
        resetn = 1'b1;
        step_cycle();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step_cycle();
        step_cycle();
        checks++;
        if (player_x !== 10'd80 || player_y !== 9'd80) begin
            failures++;
            $display("FAIL reset_pos: got (%0d,%0d) expected (80,80)", player_x, player_y);
        end
        checks++;
        if (busy !== 1'b0 || moved !== 1'b0 || bump !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got busy=%0b moved=%0b bump=%0b expected 0 0 0", busy, moved, bump);
        end
        checks++;
        if (query_x !== 10'd0 || query_y !== 9'd0) begin
            failures++;
            $display("FAIL reset_query: got (%0d,%0d) expected (0,0)", query_x, query_y);
        end
        resetn = 1'b1;
        step_cycle();
        $display("reset: player=(%0d,%0d) busy=%0b", player_x, player_y, busy);
    endtask

    task automatic test_move_right();
        frame_tick = 1'b1;
        dir        = 4'b0001;
        step_cycle();
        frame_tick = 1'b0;
        checks++;
        if (query_x !== 10'd89 || query_y !== 9'd80 || busy !== 1'b1) begin
            failures++;
            $display("FAIL move_corner_a: got (%0d,%0d) busy=%0b expected (89,80) busy=1", query_x, query_y, busy);
        end
        step_cycle();
        checks++;
        if (query_x !== 10'd89 || query_y !== 9'd87) begin
            failures++;
            $display("FAIL move_corner_b: got (%0d,%0d) expected (89,87)", query_x, query_y);
        end
        step_cycle();
        checks++;
        if (player_x !== 10'd80 || moved !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL move_early: got x=%0d moved=%0b busy=%0b expected x=80 moved=0 busy=1", player_x, moved, busy);
        end
        step_cycle();
        checks++;
        if (player_x !== 10'd82 || player_y !== 9'd80 || moved !== 1'b1 || bump !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL move_commit: got (%0d,%0d) moved=%0b bump=%0b busy=%0b expected (82,80) 1 0 0",
                     player_x, player_y, moved, bump, busy);
        end
        step_cycle();
        checks++;
        if (moved !== 1'b0) begin
            failures++;
            $display("FAIL move_pulse: got moved=%0b expected 0", moved);
        end
        dir = 4'd0;
        $display("move_right: player=(%0d,%0d)", player_x, player_y);
    endtask

    task automatic test_wall_bump();
        int r;
        bit all_moved;
        all_moved = 1'b1;
        for (int i = 0; i < 250 && player_x != 10'd520; i++) begin
            do_move(4'b0001, r);
            if (r != 1) all_moved = 1'b0;
        end
        checks++;
        if (player_x !== 10'd520 || !all_moved) begin
            failures++;
            $display("FAIL walk_right: got x=%0d all_moved=%0b expected x=520 all_moved=1", player_x, all_moved);
        end
        frame_tick = 1'b1;
        dir        = 4'b0001;
        step_cycle();
        frame_tick = 1'b0;
        checks++;
        if (query_x !== 10'd529 || query_y !== 9'd80) begin
            failures++;
            $display("FAIL bump_corner: got (%0d,%0d) expected (529,80)", query_x, query_y);
        end
        step_cycle();
        step_cycle();
        step_cycle();
        checks++;
        if (bump !== 1'b1 || moved !== 1'b0 || player_x !== 10'd520) begin
            failures++;
            $display("FAIL wall_bump: got bump=%0b moved=%0b x=%0d expected 1 0 520", bump, moved, player_x);
        end
        step_cycle();
        checks++;
        if (bump !== 1'b0) begin
            failures++;
            $display("FAIL bump_pulse: got bump=%0b expected 0", bump);
        end
        dir = 4'd0;
        $display("wall_bump: player=(%0d,%0d)", player_x, player_y);
    endtask

    task automatic test_priority_drop();
        int r;
        int n_moved;
        int n_bump;
        do_move(4'b0100, r);
        checks++;
        if (r != 1 || player_y !== 9'd82 || player_x !== 10'd520) begin
            failures++;
            $display("FAIL move_down: got r=%0d (%0d,%0d) expected 1 (520,82)", r, player_x, player_y);
        end
        n_moved    = 0;
        n_bump     = 0;
        dir        = 4'b1011;
        frame_tick = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step_cycle();
            if (i == 2) frame_tick = 1'b0;
            if (moved) n_moved++;
            if (bump) n_bump++;
        end
        dir = 4'd0;
        checks++;
        if (n_moved != 1 || n_bump != 0) begin
            failures++;
            $display("FAIL drop_busy_tick: got moved=%0d bump=%0d expected 1 0", n_moved, n_bump);
        end
        checks++;
        if (player_x !== 10'd520 || player_y !== 9'd80) begin
            failures++;
            $display("FAIL up_priority: got (%0d,%0d) expected (520,80)", player_x, player_y);
        end
        $display("priority: player=(%0d,%0d) moves=%0d", player_x, player_y, n_moved);
    endtask

`ifdef PLAYER_BUMP_CNT_EN
    task automatic test_bump_count();
        int r;
        for (int i = 0; i < 300; i++) do_move(4'b0001, r);
        checks++;
        if (bump_count !== 8'd255) begin
            failures++;
            $display("FAIL bump_count_sat: got %0d expected 255", bump_count);
        end
        $display("bump_count: %0d", bump_count);
    endtask
`endif

    task automatic test_region();
        int r;
        apply_reset();
        stub_open = 1'b1;
        for (int i = 0; i < 8; i++) do_move(4'b0010, r);
        checks++;
        if (player_x !== 10'd64 || query_x !== 10'd64 || query_y !== 9'd87) begin
            failures++;
            $display("FAIL walk_left: got x=%0d q=(%0d,%0d) expected 64 (64,87)", player_x, query_x, query_y);
        end
        frame_tick = 1'b1;
        dir        = 4'b0010;
        step_cycle();
        frame_tick = 1'b0;
        checks++;
        if (busy !== 1'b1 || query_x !== 10'd64 || query_y !== 9'd87) begin
            failures++;
            $display("FAIL region_noprobe: got busy=%0b q=(%0d,%0d) expected 1 (64,87)", busy, query_x, query_y);
        end
        step_cycle();
        checks++;
        if (bump !== 1'b1 || moved !== 1'b0 || player_x !== 10'd64 || query_x !== 10'd64) begin
            failures++;
            $display("FAIL region_bump: got bump=%0b moved=%0b x=%0d qx=%0d expected 1 0 64 64",
                     bump, moved, player_x, query_x);
        end
        dir       = 4'd0;
        stub_open = 1'b0;
        step_cycle();
        $display("region: player=(%0d,%0d)", player_x, player_y);
    endtask

    task automatic test_reset_mid_move();
        int r;
        int n_ev;
        apply_reset();
        do_move(4'b0001, r);
        checks++;
        if (player_x !== 10'd82) begin
            failures++;
            $display("FAIL premove: got x=%0d expected 82", player_x);
        end
        frame_tick = 1'b1;
        dir        = 4'b0001;
        step_cycle();
        frame_tick = 1'b0;
        step_cycle();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (player_x !== 10'd80 || player_y !== 9'd80 || busy !== 1'b0 || query_x !== 10'd0 || query_y !== 9'd0) begin
            failures++;
            $display("FAIL async_reset: got (%0d,%0d) busy=%0b q=(%0d,%0d) expected (80,80) 0 (0,0)",
                     player_x, player_y, busy, query_x, query_y);
        end
        step_cycle();
        resetn = 1'b1;
        dir    = 4'd0;
        n_ev   = 0;
        for (int i = 0; i < 6; i++) begin
            step_cycle();
            if (moved || bump) n_ev++;
        end
        checks++;
        if (n_ev != 0 || player_x !== 10'd80) begin
            failures++;
            $display("FAIL abort_move: got events=%0d x=%0d expected 0 80", n_ev, player_x);
        end
        $display("reset_mid_move: player=(%0d,%0d)", player_x, player_y);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        resetn     = 1'b0;
        frame_tick = 1'b0;
        dir        = 4'd0;
        stub_open  = 1'b0;
        test_reset();
        test_move_right();
        test_wall_bump();
        test_priority_drop();
`ifdef PLAYER_BUMP_CNT_EN
        test_bump_count();
`endif
        test_region();
        test_reset_mid_move();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
